// File: rtl/iic_byte_phy_if.sv
// Command/response channel between the I2C sequencing FSM and the byte PHY.
interface iic_byte_phy_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_ack_in;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       bus_busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_ack_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_nack, bus_busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_ack_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_nack, bus_busy
    );
endinterface

// File: rtl/iic_byte_phy.sv
// Byte-level I2C bus engine: START/WRITE/READ/STOP with quarter-bit timing
// and SCL clock stretching on open-drain SCL_T/SDA_T controls.
module iic_byte_phy #(
    parameter int QUARTER_DIV = 4
) (
    input  logic          clk_i2c,
    input  logic          reset,
    iic_byte_phy_if.slave cmd,
    input  logic          SCL_I,
    input  logic          SDA_I,
    output logic          SCL_T,
    output logic          SDA_T
);
    localparam int DW = $clog2(QUARTER_DIV);
    localparam int BW = $clog2(9);
    localparam logic [DW-1:0] DIV_LAST = DW'(QUARTER_DIV - 1);
    localparam logic [BW-1:0] BIT_ACK = BW'(8);

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        STOP,
        RESP
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [1:0]    q, q_nxt;
    logic [BW-1:0] bit_idx, bit_nxt;

    logic [1:0] op_r;
    logic [7:0] data_r;
    logic       ack_r;
    logic [7:0] shreg;
    logic       ack_smp;
    logic       busy_r, busy_nxt;
    logic [7:0] rdata_r, rdata_nxt;
    logic       rnack_r, rnack_nxt;
    logic       scl_nxt, sda_nxt;

    logic       accept, stretch, q_end, q_start;
    logic [1:0] op_sel;
    logic [7:0] data_sel;
    logic       ack_sel;
    logic       bit_val;

    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.rsp_valid = (state == RESP);
    assign cmd.rsp_data  = rdata_r;
    assign cmd.rsp_nack  = rnack_r;
    assign cmd.bus_busy  = busy_r;

    always_ff @(posedge clk_i2c) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            q       <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            q       <= q_nxt;
            bit_idx <= bit_nxt;
        end
    end

    always_comb begin
        accept    = cmd.cmd_valid && (state == IDLE);
        // A released SCL still read low means the slave is stretching.
        stretch   = SCL_T && !SCL_I;
        q_end     = (div_cnt == DIV_LAST) && !stretch;
        op_sel    = accept ? cmd.cmd_op : op_r;
        data_sel  = accept ? cmd.cmd_data : data_r;
        ack_sel   = accept ? cmd.cmd_ack_in : ack_r;
        state_nxt = state;
        div_nxt   = div_cnt;
        q_nxt     = q;
        bit_nxt   = bit_idx;
        q_start   = 1'b0;
        busy_nxt  = busy_r;
        rdata_nxt = rdata_r;
        rnack_nxt = rnack_r;

        if (state != IDLE && state != RESP && !stretch)
            div_nxt = q_end ? '0 : div_cnt + 1'b1;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    div_nxt = '0;
                    q_nxt   = '0;
                    bit_nxt = '0;
                    unique case (cmd.cmd_op)
                        OP_START: begin
                            state_nxt = START;
                            busy_nxt  = 1'b1;
                        end
                        OP_STOP: state_nxt = busy_r ? STOP : RESP;
                        default: state_nxt = busy_r ? BIT : RESP;
                    endcase
                    q_start = (state_nxt != RESP);
                    if (state_nxt == RESP) begin
                        rdata_nxt = '0;
                        rnack_nxt = 1'b1;
                    end
                end
            end
            START, STOP: begin
                if (q_end) begin
                    if (q == 2'd3) begin
                        state_nxt = RESP;
                        rdata_nxt = '0;
                        rnack_nxt = 1'b0;
                        if (state == STOP) busy_nxt = 1'b0;
                    end else begin
                        q_nxt   = q + 1'b1;
                        q_start = 1'b1;
                    end
                end
            end
            BIT: begin
                if (q_end) begin
                    if (q != 2'd3) begin
                        q_nxt   = q + 1'b1;
                        q_start = 1'b1;
                    end else if (bit_idx != BIT_ACK) begin
                        bit_nxt = bit_idx + 1'b1;
                        q_nxt   = '0;
                        q_start = 1'b1;
                    end else begin
                        state_nxt = RESP;
                        rdata_nxt = (op_r == OP_READ) ? shreg : '0;
                        rnack_nxt = (op_r == OP_WRITE) && ack_smp;
                    end
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        bit_val = 1'b1;
        if (bit_nxt == BIT_ACK)
            bit_val = (op_sel == OP_READ) ? ack_sel : 1'b1;
        else if (op_sel == OP_WRITE)
            bit_val = data_sel[3'd7 - bit_nxt[2:0]];

        // Line levels are loaded once, at the edge that opens a quarter.
        scl_nxt = SCL_T;
        sda_nxt = SDA_T;
        if (q_start) begin
            unique case (state_nxt)
                START: begin
                    unique case (q_nxt)
                        2'd0: sda_nxt = 1'b1;
                        2'd1: begin scl_nxt = 1'b1; sda_nxt = 1'b1; end
                        2'd2: begin scl_nxt = 1'b1; sda_nxt = 1'b0; end
                        default: begin scl_nxt = 1'b0; sda_nxt = 1'b0; end
                    endcase
                end
                BIT: begin
                    unique case (q_nxt)
                        2'd0: begin scl_nxt = 1'b0; sda_nxt = bit_val; end
                        2'd1, 2'd2: scl_nxt = 1'b1;
                        default: scl_nxt = 1'b0;
                    endcase
                end
                STOP: begin
                    unique case (q_nxt)
                        2'd0: begin scl_nxt = 1'b0; sda_nxt = 1'b0; end
                        2'd1, 2'd2: begin scl_nxt = 1'b1; sda_nxt = 1'b0; end
                        default: begin scl_nxt = 1'b1; sda_nxt = 1'b1; end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i2c) begin
        if (reset) begin
            op_r    <= '0;
            data_r  <= '0;
            ack_r   <= 1'b0;
            shreg   <= '0;
            ack_smp <= 1'b0;
            busy_r  <= 1'b0;
            rdata_r <= '0;
            rnack_r <= 1'b0;
            SCL_T   <= 1'b1;
            SDA_T   <= 1'b1;
        end else begin
            busy_r  <= busy_nxt;
            rdata_r <= rdata_nxt;
            rnack_r <= rnack_nxt;
            SCL_T   <= scl_nxt;
            SDA_T   <= sda_nxt;
            if (accept) begin
                op_r   <= cmd.cmd_op;
                data_r <= cmd.cmd_data;
                ack_r  <= cmd.cmd_ack_in;
            end
            if (state == BIT && q == 2'd2 && q_end) begin
                if (bit_idx == BIT_ACK)
                    ack_smp <= SDA_I;
                else
                    shreg <= {shreg[6:0], SDA_I};
            end
        end
    end
endmodule

// File: tb/tb_iic_byte_phy.sv
// Scoreboard bench for iic_byte_phy with a simple open-drain slave model.
module tb_iic_byte_phy;
    localparam int QD = 4;
    localparam int LAT_SS = 4 * QD + 1;
    localparam int LAT_BYTE = 36 * QD + 1;
    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    typedef struct {
        logic [7:0] data;
        logic       nack;
        int         lat;
        int         acc;
    } exp_t;

    logic clk_i2c = 1'b0;
    logic reset = 1'b1;
    logic SCL_I, SDA_I, SCL_T, SDA_T;
    logic slave_sda = 1'b1;
    logic stretch = 1'b0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic [8:0] rise_bits = '0;
    int   rise_cnt = 0;

    iic_byte_phy_if bus ();

    iic_byte_phy #(.QUARTER_DIV(QD)) dut (
        .clk_i2c(clk_i2c),
        .reset(reset),
        .cmd(bus),
        .SCL_I(SCL_I),
        .SDA_I(SDA_I),
        .SCL_T(SCL_T),
        .SDA_T(SDA_T)
    );

    assign SCL_I = SCL_T & ~stretch;
    assign SDA_I = SDA_T & slave_sda;

    always #5 clk_i2c = ~clk_i2c;

    always @(posedge clk_i2c) cyc++;

    // SDA level seen by the bus at every SCL rising edge.
    always @(posedge SCL_T) begin
        rise_bits = {rise_bits[7:0], SDA_T};
        rise_cnt++;
    end

    always @(posedge clk_i2c) begin
        #1;
        if (bus.rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp got rsp_valid=1 want none (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                checks++;
                if (bus.rsp_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL rsp_data got %h want %h", bus.rsp_data, mon_e.data);
                end
                checks++;
                if (bus.rsp_nack !== mon_e.nack) begin
                    errors++;
                    $display("FAIL rsp_nack got %b want %b", bus.rsp_nack, mon_e.nack);
                end
                checks++;
                if (cyc - mon_e.acc != mon_e.lat) begin
                    errors++;
                    $display("FAIL rsp_latency got %0d want %0d", cyc - mon_e.acc, mon_e.lat);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic ack,
                         input logic [7:0] ed, input logic en, input int el);
        int   g;
        exp_t e;
        g = 0;
        while (bus.cmd_ready !== 1'b1 && g < 2000) begin
            @(posedge clk_i2c);
            #1;
            g++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_ready got %b want 1", bus.cmd_ready);
        end
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_data   = d;
        bus.cmd_ack_in = ack;
        e.data = ed;
        e.nack = en;
        e.lat  = el;
        e.acc  = cyc;
        sbq.push_back(e);
        @(posedge clk_i2c);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 4000) begin
            @(posedge clk_i2c);
            #2;
            g++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout pending %0d want 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_i2c);
        #1;
        reset = 1'b0;
        checks++;
        if ({SCL_T, SDA_T} !== 2'b11) begin
            errors++;
            $display("FAIL reset_lines got %b%b want 11", SCL_T, SDA_T);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid);
        end
        checks++;
        if ({bus.rsp_data, bus.rsp_nack} !== 9'h000) begin
            errors++;
            $display("FAIL reset_rsp got %h/%b want 00/0", bus.rsp_data, bus.rsp_nack);
        end
        checks++;
        if (bus.bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus.bus_busy);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_start();
        int sda_fall, scl_fall;
        sda_fall = -1;
        scl_fall = -1;
        issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, LAT_SS);
        checks++;
        if (bus.bus_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy_rise got %b want 1", bus.bus_busy);
        end
        for (int n = 1; n <= 4 * QD; n++) begin
            if (sda_fall < 0 && SDA_T === 1'b0) begin
                sda_fall = n;
                checks++;
                if (SCL_T !== 1'b1) begin
                    errors++;
                    $display("FAIL start_scl_high got %b want 1", SCL_T);
                end
            end
            if (scl_fall < 0 && SCL_T === 1'b0) scl_fall = n;
            @(posedge clk_i2c);
            #1;
        end
        checks++;
        if (sda_fall != 2 * QD + 1) begin
            errors++;
            $display("FAIL start_sda_fall got %0d want %0d", sda_fall, 2 * QD + 1);
        end
        checks++;
        if (scl_fall != 3 * QD + 1) begin
            errors++;
            $display("FAIL start_scl_fall got %0d want %0d", scl_fall, 3 * QD + 1);
        end
        wait_done();
        checks++;
        if (bus.bus_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy got %b want 1", bus.bus_busy);
        end
    endtask

    task automatic test_write();
        logic sl;
        for (int i = 0; i < 2; i++) begin
            sl = (i == 1);
            slave_sda = sl;
            rise_cnt = 0;
            issue(OP_WRITE, 8'hA5, 1'b0, 8'h00, sl, LAT_BYTE);
            wait_done();
            checks++;
            if (rise_cnt != 9 || rise_bits !== {8'hA5, 1'b1}) begin
                errors++;
                $display("FAIL write_bits got %0d/%b want 9/%b", rise_cnt, rise_bits, {8'hA5, 1'b1});
            end
        end
        slave_sda = 1'b1;
    endtask

    task automatic test_read_stop();
        logic [7:0] rb;
        logic       ak;
        int         sda_rise;
        for (int i = 0; i < 2; i++) begin
            rb = (i == 0) ? 8'h3C : 8'h96;
            ak = (i == 0);
            rise_cnt = 0;
            issue(OP_READ, 8'h00, ak, rb, 1'b0, LAT_BYTE);
            for (int n = 1; n <= 36 * QD; n++) begin
                int k;
                k = (n - 1) / (4 * QD);
                slave_sda = (k < 8) ? rb[7 - k] : 1'b1;
                if (n == 33 * QD + 2) begin
                    checks++;
                    if (SDA_T !== ak) begin
                        errors++;
                        $display("FAIL read_ack_drive got %b want %b", SDA_T, ak);
                    end
                end
                @(posedge clk_i2c);
                #1;
            end
            slave_sda = 1'b1;
            wait_done();
            checks++;
            if (rise_cnt != 9 || rise_bits !== {8'hFF, ak}) begin
                errors++;
                $display("FAIL read_bits got %0d/%b want 9/%b", rise_cnt, rise_bits, {8'hFF, ak});
            end
        end
        sda_rise = -1;
        issue(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, LAT_SS);
        for (int n = 1; n <= 4 * QD; n++) begin
            if (sda_rise < 0 && SDA_T === 1'b1) begin
                sda_rise = n;
                checks++;
                if (SCL_T !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_scl_high got %b want 1", SCL_T);
                end
            end
            if (n == 4 * QD) begin
                checks++;
                if (bus.bus_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_busy_hold got %b want 1", bus.bus_busy);
                end
            end
            @(posedge clk_i2c);
            #1;
        end
        checks++;
        if (sda_rise != 3 * QD + 1) begin
            errors++;
            $display("FAIL stop_sda_rise got %0d want %0d", sda_rise, 3 * QD + 1);
        end
        wait_done();
        checks++;
        if (bus.bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_busy got %b want 0", bus.bus_busy);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] ops [3];
        ops = '{OP_WRITE, OP_READ, OP_STOP};
        for (int i = 0; i < 3; i++) begin
            rise_cnt = 0;
            issue(ops[i], 8'hFF, 1'b0, 8'h00, 1'b1, 1);
            wait_done();
            @(posedge clk_i2c);
            #1;
            checks++;
            if ({SCL_T, SDA_T} !== 2'b11 || rise_cnt != 0 || bus.bus_busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_idle op %0d got %b%b/%0d/%b want 11/0/0",
                         ops[i], SCL_T, SDA_T, rise_cnt, bus.bus_busy);
            end
        end
    endtask

    task automatic test_stretch();
        int s0, scl_fall;
        s0 = 1 + 12 * QD + QD;
        scl_fall = -1;
        issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, LAT_SS);
        wait_done();
        slave_sda = 1'b0;
        rise_cnt = 0;
        issue(OP_WRITE, 8'h5A, 1'b0, 8'h00, 1'b0, LAT_BYTE + 10);
        for (int n = 1; n <= 36 * QD + 10; n++) begin
            stretch = (n >= s0 && n < s0 + 10);
            if (n > s0 && scl_fall < 0 && SCL_T === 1'b0) scl_fall = n;
            @(posedge clk_i2c);
            #1;
        end
        stretch = 1'b0;
        wait_done();
        slave_sda = 1'b1;
        checks++;
        if (scl_fall != s0 + 2 * QD + 10) begin
            errors++;
            $display("FAIL stretch_scl_fall got %0d want %0d", scl_fall, s0 + 2 * QD + 10);
        end
        checks++;
        if (rise_cnt != 9 || rise_bits !== {8'h5A, 1'b1}) begin
            errors++;
            $display("FAIL stretch_bits got %0d/%b want 9/%b", rise_cnt, rise_bits, {8'h5A, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        issue(OP_READ, 8'h00, 1'b0, 8'h00, 1'b0, LAT_BYTE);
        void'(sbq.pop_back());
        for (int n = 1; n < 1 + 20 * QD + 2; n++) begin
            @(posedge clk_i2c);
            #1;
        end
        reset = 1'b1;
        @(posedge clk_i2c);
        #1;
        checks++;
        if ({SCL_T, SDA_T} !== 2'b11 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_lines got %b%b/%b want 11/0", SCL_T, SDA_T, bus.rsp_valid);
        end
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state got ready %b busy %b want 1 0", bus.cmd_ready, bus.bus_busy);
        end
        reset = 1'b0;
        repeat (200) @(posedge clk_i2c);
        #1;
    endtask

    task automatic test_back_to_back();
        slave_sda = 1'b1;
        issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, LAT_SS);
        issue(OP_WRITE, 8'h81, 1'b0, 8'h00, 1'b1, LAT_BYTE);
        issue(OP_READ, 8'h00, 1'b1, 8'hFF, 1'b0, LAT_BYTE);
        issue(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, LAT_SS);
        wait_done();
        checks++;
        if (bus.bus_busy !== 1'b0 || {SCL_T, SDA_T} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_end got busy %b lines %b%b want 0 11", bus.bus_busy, SCL_T, SDA_T);
        end
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 2'b00;
        bus.cmd_data   = 8'h00;
        bus.cmd_ack_in = 1'b0;
        test_reset();
        test_start();
        test_write();
        test_read_stop();
        test_illegal();
        test_stretch();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
